// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   PC_W          default word-address width of the program counter
//   INST_W        instruction word width
//   fetch_entry_t {pc, inst} pair as held in the fetch queue
package fetch_pkg;

  parameter int PC_W   = 12;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular queue with a registered head.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush_i        empties the queue this edge; wins over push and pop
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   head_o         registered head entry; holds its last value when empty,
//                  zero after reset
//   count_o        number of occupied entries
module fetch_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);
  assign rd_next = rd_ptr_q + PW'(1);

  // The head register is loaded with whatever entry becomes the head on
  // this edge, so it never changes while the queue is non-empty and
  // nothing is popped.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_next;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_pop) begin
        if (count_q > CW'(1)) head_d = mem_q[rd_next];
        else if (do_push)     head_d = push_data_i;
      end else if ((count_q == '0) && do_push) begin
        head_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the execute stage.
// Holds the PC, issues one word read per cycle to a synchronous-read
// instruction memory, queues returned words and hands them to execute.
// A redirect from execute flushes everything fetched or in flight and
// restarts fetch at the target.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_en/imem_addr   read strobe and word address (= current PC)
//   imem_rdata          read data, valid the cycle after imem_en
//   inst_valid/inst_data/inst_pc  queue head offered to execute
//   ex_ready            execute takes the head this cycle
//   redirect_valid/redirect_pc    taken branch/jump target
//   perf_accept_cnt, perf_redirect_cnt  only when FETCH_PERF_CNT_EN is defined
// Handshake: an instruction transfers on a rising edge where inst_valid and
// ex_ready are both high; while inst_valid && !ex_ready the head (inst_data,
// inst_pc) is held stable. A redirect in the same cycle cancels the transfer.
// Optional feature macro: FETCH_PERF_CNT_EN (accept/redirect counters).
module fetch_unit #(
  parameter int              PC_W     = 12,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc,
  input  logic            ex_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_accept_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  import fetch_pkg::INST_W;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + INST_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            push;
  logic            issue;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && ex_ready;

  // Credit check: queued entries plus the read in flight, minus the entry
  // leaving this cycle, must leave room for the word we are about to ask for.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight_q && !discard_q;

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    discard_d     = 1'b0;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      discard_d = inflight_q;
    end else if (issue) begin
      pc_d          = pc_q + PC_W'(1);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
    end
  end

  // Redirect drives flush, which the queue gives priority over push/pop.
  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({inflight_pc_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign inst_pc   = head[EW-1:INST_W];
  assign inst_data = head[INST_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] accept_cnt_q;
  logic [31:0] redirect_cnt_q;

  // A pop cancelled by a simultaneous redirect is not an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (pop && !redirect_valid) accept_cnt_q <= accept_cnt_q + 32'd1;
      if (redirect_valid)         redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_accept_cnt   = accept_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// dut0 starts at PC 0 and takes redirects; dut1 starts at 0xFFE to show the
// PC wrap. Each instruction memory returns 0x20000000 + address.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ex_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;

  logic        en0, valid0, en1, valid1;
  logic [11:0] addr0, pc0, addr1, pc1;
  logic [31:0] rdata0, data0, rdata1, data1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] acc0, red0, acc1, red1;
`endif

  fetch_unit #(.PC_W(12), .DEPTH(2), .RESET_PC(12'h000)) dut0 (
    .clk(clk), .rst(rst),
    .imem_en(en0), .imem_addr(addr0), .imem_rdata(rdata0),
    .inst_valid(valid0), .inst_data(data0), .inst_pc(pc0),
    .ex_ready(ex_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_accept_cnt(acc0), .perf_redirect_cnt(red0)
`endif
  );

  fetch_unit #(.PC_W(12), .DEPTH(2), .RESET_PC(12'hFFE)) dut1 (
    .clk(clk), .rst(rst),
    .imem_en(en1), .imem_addr(addr1), .imem_rdata(rdata1),
    .inst_valid(valid1), .inst_data(data1), .inst_pc(pc1),
    .ex_ready(ex_ready),
    .redirect_valid(1'b0), .redirect_pc(12'h000)
`ifdef FETCH_PERF_CNT_EN
    , .perf_accept_cnt(acc1), .perf_redirect_cnt(red1)
`endif
  );

  // Synchronous-read memories; garbage when not read so stale data shows up.
  always @(posedge clk) rdata0 <= en0 ? (32'h2000_0000 + {20'd0, addr0}) : $urandom();
  always @(posedge clk) rdata1 <= en1 ? (32'h2000_0000 + {20'd0, addr1}) : $urandom();

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_pc;
  logic [11:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    ex_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", en0); end
    checks++; if (addr0 !== 12'h000) begin failures++; $display("FAIL reset_addr0 got=%h exp=000", addr0); end
    checks++; if (addr1 !== 12'hFFE) begin failures++; $display("FAIL reset_addr1 got=%h exp=ffe", addr1); end
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid0); end
    checks++; if (data0 !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data0); end
    checks++; if (pc0 !== 12'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc0); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (acc0 !== 32'd0 || red0 !== 32'd0 || acc1 !== 32'd0 || red1 !== 32'd0) begin
      failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", acc0, red0);
    end
`endif
  endtask

  // Continues straight from test_reset: cycle 0 is the first with rst low.
  task automatic test_stream();
    logic [11:0] e1;
    for (int k = 0; k < 12; k++) begin
      rst = 1'b0;
      #1;
      checks++; if (en0 !== 1'b1 || addr0 !== 12'(k)) begin
        failures++; $display("FAIL stream_issue k=%0d got=%b/%h exp=1/%h", k, en0, addr0, 12'(k));
      end
      if (k >= 2) begin
        checks++; if (valid0 !== 1'b1 || pc0 !== 12'(k-2) || data0 !== 32'h2000_0000 + 32'(k-2)) begin
          failures++; $display("FAIL stream_out k=%0d got=%b/%h/%h exp=1/%h", k, valid0, pc0, data0, 12'(k-2));
        end
        e1 = 12'hFFE + 12'(k-2);
        checks++; if (valid1 !== 1'b1 || pc1 !== e1 || data1 !== 32'h2000_0000 + {20'd0, e1}) begin
          failures++; $display("FAIL wrap_out k=%0d got=%b/%h/%h exp=1/%h", k, valid1, pc1, data1, e1);
        end
      end else begin
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL stream_latency k=%0d got=%b exp=0", k, valid0); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_pc = 12'h000;
    for (int k = 0; k < 17; k++) begin
      rst = 1'b0;
      ex_ready = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      #1;
      if (k >= 4 && k <= 8) begin
        checks++; if (en0 !== 1'b0 || valid0 !== 1'b1 || pc0 !== 12'h002) begin
          failures++; $display("FAIL stall_hold k=%0d got=en%b/v%b/%h exp=en0/v1/002", k, en0, valid0, pc0);
        end
      end
      if (k >= 9) begin
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL stall_gap k=%0d got=%b exp=1", k, valid0); end
      end
      if (valid0 && ex_ready) begin
        checks++; if (pc0 !== exp_pc || data0 !== 32'h2000_0000 + {20'd0, exp_pc}) begin
          failures++; $display("FAIL stall_seq k=%0d got=%h/%h exp=%h", k, pc0, data0, exp_pc);
        end
        exp_pc = exp_pc + 12'd1;
      end
      @(negedge clk);
    end
    checks++; if (exp_pc !== 12'd10) begin failures++; $display("FAIL stall_total got=%0d exp=10", exp_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    exp_pc = 12'h000;
    for (int k = 0; k < 13; k++) begin
      rst = 1'b0;
      redirect_valid = (k == 5);
      redirect_pc = 12'h100;
      #1;
      if (k == 5) begin
        checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL redir_noissue got=%b exp=0", en0); end
        exp_pc = 12'h100;
      end else begin
        if (k == 6) begin
          checks++; if (en0 !== 1'b1 || addr0 !== 12'h100) begin
            failures++; $display("FAIL redir_restart got=%b/%h exp=1/100", en0, addr0);
          end
        end
        if (k == 6 || k == 7) begin
          checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL redir_flush k=%0d got=%b exp=0", k, valid0); end
        end
        if (k == 8) begin
          checks++; if (valid0 !== 1'b1 || pc0 !== 12'h100) begin
            failures++; $display("FAIL redir_first got=%b/%h exp=1/100", valid0, pc0);
          end
        end
        if (valid0 && ex_ready) begin
          checks++; if (pc0 !== exp_pc || data0 !== 32'h2000_0000 + {20'd0, exp_pc}) begin
            failures++; $display("FAIL redir_seq k=%0d got=%h/%h exp=%h", k, pc0, data0, exp_pc);
          end
          exp_pc = exp_pc + 12'd1;
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rst = 1'b0;
      redirect_valid = (k == 4 || k == 5);
      redirect_pc = (k == 4) ? 12'h010 : 12'h020;
      #1;
      if (k == 5) begin
        checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL b2b_noissue got=%b exp=0", en0); end
      end
      if (k == 6) begin
        checks++; if (en0 !== 1'b1 || addr0 !== 12'h020) begin
          failures++; $display("FAIL b2b_restart got=%b/%h exp=1/020", en0, addr0);
        end
      end
      if (k == 6 || k == 7) begin
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL b2b_flush k=%0d got=%b exp=0", k, valid0); end
      end
      if (k == 8) begin
        checks++; if (valid0 !== 1'b1 || pc0 !== 12'h020 || data0 !== 32'h2000_0020) begin
          failures++; $display("FAIL b2b_first got=%b/%h/%h exp=1/020", valid0, pc0, data0);
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_perf_and_mid_reset();
    int nacc, nred;
    do_reset();
    nacc = 0; nred = 0;
    exp_pc = 12'h000;
    for (int k = 0; k < 40 && nacc < 10; k++) begin
      rst = 1'b0;
      redirect_valid = (k == 7 || k == 13);
      redirect_pc = (k == 7) ? 12'h100 : 12'h200;
      ex_ready = !redirect_valid;
      #1;
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        nred++;
      end else if (valid0 && ex_ready) begin
        checks++; if (pc0 !== exp_pc) begin failures++; $display("FAIL perf_seq k=%0d got=%h exp=%h", k, pc0, exp_pc); end
        exp_pc = exp_pc + 12'd1;
        nacc++;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    ex_ready = 1'b0;
    #1;
    checks++; if (nacc != 10 || nred != 2) begin failures++; $display("FAIL perf_stim got=%0d/%0d exp=10/2", nacc, nred); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (acc0 !== 32'd10) begin failures++; $display("FAIL perf_accept got=%0d exp=10", acc0); end
    checks++; if (red0 !== 32'd2) begin failures++; $display("FAIL perf_redirect got=%0d exp=2", red0); end
`endif
    // Reset in the middle of a running stream.
    @(negedge clk);
    rst = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (valid0 !== 1'b0 || addr0 !== 12'h000 || en0 !== 1'b0) begin
      failures++; $display("FAIL midrst_state got=v%b/%h/en%b exp=v0/000/en0", valid0, addr0, en0);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (acc0 !== 32'd0 || red0 !== 32'd0) begin
      failures++; $display("FAIL midrst_perf got=%0d/%0d exp=0/0", acc0, red0);
    end
`endif
    rst = 1'b0;
    #1;
    checks++; if (en0 !== 1'b1 || addr0 !== 12'h000) begin
      failures++; $display("FAIL midrst_restart got=%b/%h exp=1/000", en0, addr0);
    end
    @(negedge clk);
    #1;
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b exp=0", valid0); end
    @(negedge clk);
    #1;
    checks++; if (valid0 !== 1'b1 || pc0 !== 12'h000 || data0 !== 32'h2000_0000) begin
      failures++; $display("FAIL midrst_first got=%b/%h/%h exp=1/000", valid0, pc0, data0);
    end
    @(negedge clk);
  endtask

  // Reference model: the accepted stream is consecutive word addresses
  // starting at the reset PC or at the latest redirect target; a held head
  // never changes; after any restart an instruction appears within 3 cycles.
  task automatic test_random();
    int          gap;
    logic        prev_hold;
    logic [11:0] prev_pc;
    logic [31:0] prev_data;
    do_reset();
    exp_q.delete();
    exp_q.push_back(12'h000);
    gap = 0;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_data = '0;
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      redirect_valid = !rst && ($urandom_range(0, 99) < 6);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                                 : 12'($urandom_range(0, 4095));
      ex_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (rst || redirect_valid) begin
        checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL rand_issue_block k=%0d got=%b exp=0", k, en0); end
      end
      if (prev_hold) begin
        checks++; if (valid0 !== 1'b1 || pc0 !== prev_pc || data0 !== prev_data) begin
          failures++; $display("FAIL rand_stable k=%0d got=%b/%h/%h exp=1/%h/%h", k, valid0, pc0, data0, prev_pc, prev_data);
        end
      end
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(12'h000);
        gap = 0;
      end else if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
        gap = 0;
      end else begin
        if (valid0) gap = 0;
        else gap++;
        checks++; if (gap > 2) begin failures++; $display("FAIL rand_starve k=%0d got=%0d exp<=2", k, gap); end
        if (valid0 && ex_ready) begin
          exp_pc = exp_q.pop_front();
          checks++; if (pc0 !== exp_pc || data0 !== 32'h2000_0000 + {20'd0, exp_pc}) begin
            failures++; $display("FAIL rand_seq k=%0d got=%h/%h exp=%h", k, pc0, data0, exp_pc);
          end
          exp_q.push_back(exp_pc + 12'd1);
        end
      end
      prev_hold = !rst && !redirect_valid && valid0 && !ex_ready;
      prev_pc = pc0;
      prev_data = data0;
      @(negedge clk);
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_perf_and_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
